// File: rtl/invader_formation_pkg.sv
// Shared playfield constants and types for the invader formation block.
package invader_formation_pkg;

  localparam int unsigned INVADERS_H        = 11;
  localparam int unsigned INVADERS_OFFSET_H = 32;
  localparam int unsigned SPRITE_WIDTH      = 16;
  localparam int unsigned SPRITE_HEIGHT     = 8;
  localparam int unsigned SPRITE_SCALE      = 2;
  localparam int unsigned INVADER_ROWS      = 5;
  localparam int unsigned ROW_PITCH         = 32;

  localparam int unsigned COL_W = $clog2(INVADERS_H);

  typedef enum logic [1:0] {StRun, StScan, StMove, StHalt} form_state_e;

endpackage

// File: rtl/formation_extent_scan.sv
// Sequential lowest/highest occupied column search, one column per cycle.
module formation_extent_scan
  import invader_formation_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [INVADERS_H-1:0] occ,
  output logic                  done,
  output logic [COL_W-1:0]      lo,
  output logic [COL_W-1:0]      hi
);

  localparam logic [COL_W-1:0] LastCol = COL_W'(INVADERS_H - 1);

  logic [INVADERS_H-1:0] occ_q;
  logic [COL_W-1:0]      idx_q;
  logic [COL_W-1:0]      lo_q;
  logic [COL_W-1:0]      hi_q;
  logic                  found_q;
  logic                  busy_q;

  // Occupancy is latched at start so kills during the scan do not disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q   <= '0;
      idx_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      found_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (start) begin
      occ_q   <= occ;
      idx_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      found_q <= 1'b0;
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      if (occ_q[idx_q]) begin
        if (!found_q) lo_q <= idx_q;
        hi_q    <= idx_q;
        found_q <= 1'b1;
      end
      idx_q <= idx_q + 1'b1;
      if (idx_q == LastCol) busy_q <= 1'b0;
    end
  end

  assign done = busy_q && (idx_q == LastCol);
  assign lo   = lo_q;
  assign hi   = hi_q;

endmodule

// File: rtl/invader_formation.sv
// Invader formation: alive matrix, marching motion, row-start sequencing and kills.
module invader_formation #(
  parameter int unsigned INVADER_ROWS = invader_formation_pkg::INVADER_ROWS,
  parameter int unsigned STEP_FRAMES  = 16,
  parameter int unsigned STEP_PX      = 2,
  parameter int unsigned DROP_PX      = 8,
  parameter int unsigned START_X      = 26,
  parameter int unsigned START_Y      = 64,
  parameter int unsigned ROW_PITCH    = invader_formation_pkg::ROW_PITCH,
  parameter int unsigned X_MIN        = 8,
  parameter int unsigned X_MAX        = 632,
  parameter int unsigned Y_LIMIT      = 400
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      frame_tick,
  input  logic                                      line_tick,
  input  logic [9:0]                                pixel_y,
  input  logic                                      kill_valid,
  input  logic [2:0]                                kill_row,
  input  logic [3:0]                                kill_col,
  output logic                                      kill_ack,
  output logic                                      row_start,
  output logic [2:0]                                row_sel,
  output logic [invader_formation_pkg::INVADERS_H-1:0] row_mask,
  output logic [9:0]                                spr_x,
  output logic [9:0]                                form_y,
  output logic                                      all_dead,
  output logic                                      landed
);
  import invader_formation_pkg::*;

  localparam int unsigned FrameW     = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam logic [FrameW-1:0] LastFrame = FrameW'(STEP_FRAMES - 1);
  localparam logic [5:0]  TotalInv   = 6'(INVADER_ROWS * INVADERS_H);
  localparam logic [10:0] SpriteSpan = 11'(SPRITE_WIDTH * SPRITE_SCALE);
  localparam logic [10:0] FormDepth  =
      11'((INVADER_ROWS - 1) * ROW_PITCH + SPRITE_HEIGHT * SPRITE_SCALE);

  logic [INVADER_ROWS-1:0][INVADERS_H-1:0] alive_q;
  logic [9:0]            x_q, y_q;
  logic                  dir_q;
  logic [FrameW-1:0]     frame_q;
  logic [5:0]            count_q;
  form_state_e           state_q;
  logic                  row_start_q, kill_ack_q, all_dead_q, landed_q;
  logic [2:0]            row_sel_q;
  logic [INVADERS_H-1:0] row_mask_q;

  logic [INVADERS_H-1:0] occ;
  logic                  scan_start, scan_done;
  logic [COL_W-1:0]      lo, hi;
  logic                  kill_in, kill_hit;
  logic                  row_hit;
  logic [2:0]            row_idx;
  logic [10:0]           right_edge, left_edge;
  logic                  drop, land_next;
  logic [9:0]            x_next, y_next;

  always_comb begin
    occ = '0;
    for (int r = 0; r < INVADER_ROWS; r++) occ = occ | alive_q[r];
  end

  always_comb begin
    kill_in  = kill_valid && (int'(kill_row) < INVADER_ROWS) && (int'(kill_col) < INVADERS_H);
    kill_hit = kill_in && alive_q[kill_row][kill_col];
  end

  always_comb begin
    row_hit = 1'b0;
    row_idx = '0;
    for (int r = 0; r < INVADER_ROWS; r++) begin
      if (line_tick && ({1'b0, pixel_y} == {1'b0, y_q} + 11'(r * ROW_PITCH))) begin
        row_hit = 1'b1;
        row_idx = 3'(r);
      end
    end
  end

  // Edges use 11-bit sums so a formation near the right limit cannot wrap.
  always_comb begin
    right_edge = {1'b0, x_q} + 11'(hi) * 11'(INVADERS_OFFSET_H) + SpriteSpan + 11'(STEP_PX);
    left_edge  = {1'b0, x_q} + 11'(lo) * 11'(INVADERS_OFFSET_H);
    drop       = dir_q ? (right_edge > 11'(X_MAX)) : (left_edge < 11'(X_MIN + STEP_PX));
    x_next     = drop ? x_q : (dir_q ? x_q + 10'(STEP_PX) : x_q - 10'(STEP_PX));
    y_next     = drop ? y_q + 10'(DROP_PX) : y_q;
    land_next  = ({1'b0, y_next} + FormDepth) >= 11'(Y_LIMIT);
  end

  assign scan_start = (state_q == StRun) && !all_dead_q && !landed_q && frame_tick &&
                      (frame_q == LastFrame);

  formation_extent_scan u_scan (
    .clk   (clk),
    .rst_n (rst_n),
    .start (scan_start),
    .occ   (occ),
    .done  (scan_done),
    .lo    (lo),
    .hi    (hi)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive_q     <= '1;
      count_q     <= TotalInv;
      x_q         <= 10'(START_X);
      y_q         <= 10'(START_Y);
      dir_q       <= 1'b1;
      frame_q     <= '0;
      state_q     <= StRun;
      row_start_q <= 1'b0;
      row_sel_q   <= '0;
      row_mask_q  <= '0;
      kill_ack_q  <= 1'b0;
      all_dead_q  <= 1'b0;
      landed_q    <= 1'b0;
    end else begin
      // Row capture reads the matrix before this cycle's kill lands.
      row_start_q <= row_hit;
      if (row_hit) begin
        row_sel_q  <= row_idx;
        row_mask_q <= alive_q[row_idx];
      end

      kill_ack_q <= kill_hit;
      if (kill_hit) begin
        alive_q[kill_row][kill_col] <= 1'b0;
        count_q <= count_q - 6'd1;
      end
      all_dead_q <= (count_q == 6'd0);

      unique case (state_q)
        StRun: begin
          if (all_dead_q || landed_q) begin
            state_q <= StHalt;
          end else if (frame_tick) begin
            if (frame_q == LastFrame) begin
              frame_q <= '0;
              state_q <= StScan;
            end else begin
              frame_q <= frame_q + 1'b1;
            end
          end
        end
        StScan: if (scan_done) state_q <= StMove;
        StMove: begin
          x_q      <= x_next;
          y_q      <= y_next;
          if (drop) dir_q <= ~dir_q;
          landed_q <= landed_q | land_next;
          state_q  <= (land_next || landed_q || all_dead_q) ? StHalt : StRun;
        end
        StHalt: state_q <= StHalt;
        default: state_q <= StRun;
      endcase
    end
  end

  assign kill_ack  = kill_ack_q;
  assign row_start = row_start_q;
  assign row_sel   = row_sel_q;
  assign row_mask  = row_mask_q;
  assign spr_x     = x_q;
  assign form_y    = y_q;
  assign all_dead  = all_dead_q;
  assign landed    = landed_q;

endmodule

// File: tb/tb_invader_formation.sv
// Bench for invader_formation: row-start table with scoreboard, kills and march sequences.
module tb_invader_formation;
  import invader_formation_pkg::*;

  localparam int ROWS = 5;
  localparam int COLS = INVADERS_H;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            frame_tick = 1'b0;
  logic            line_tick = 1'b0;
  logic [9:0]      pixel_y = '0;
  logic            kill_valid = 1'b0;
  logic [2:0]      kill_row = '0;
  logic [3:0]      kill_col = '0;
  logic            kill_ack, row_start, all_dead, landed;
  logic [2:0]      row_sel;
  logic [COLS-1:0] row_mask;
  logic [9:0]      spr_x, form_y;

  invader_formation dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .line_tick  (line_tick),
    .pixel_y    (pixel_y),
    .kill_valid (kill_valid),
    .kill_row   (kill_row),
    .kill_col   (kill_col),
    .kill_ack   (kill_ack),
    .row_start  (row_start),
    .row_sel    (row_sel),
    .row_mask   (row_mask),
    .spr_x      (spr_x),
    .form_y     (form_y),
    .all_dead   (all_dead),
    .landed     (landed)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [2:0]      sel;
    logic [COLS-1:0] mask;
  } row_ev_t;
  row_ev_t exp_q[$];

  typedef struct {
    int py;
    int r;
  } row_vec_t;
  row_vec_t tbl[9];

  logic [COLS-1:0] m_alive [ROWS];
  int m_x, m_y;
  bit m_dir;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every row_start pops one expected {row_sel,row_mask}.
  always @(negedge clk) begin
    row_ev_t e;
    if (rst_n && row_start) begin
      if (exp_q.size() == 0) begin
        check("row_start_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("row_sel", int'(row_sel), int'(e.sel));
        check("row_mask", int'(row_mask), int'(e.mask));
      end
    end
  end

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++) m_alive[r] = '1;
    m_x = 26;
    m_y = 64;
    m_dir = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    check("rst_spr_x", int'(spr_x), 26);
    check("rst_form_y", int'(form_y), 64);
    check("rst_row_start", int'(row_start), 0);
    check("rst_row_sel", int'(row_sel), 0);
    check("rst_row_mask", int'(row_mask), 0);
    check("rst_kill_ack", int'(kill_ack), 0);
    check("rst_all_dead", int'(all_dead), 0);
    check("rst_landed", int'(landed), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    cyc();
  endtask

  task automatic model_step();
    logic [COLS-1:0] occ;
    int lo, hi;
    occ = '0;
    for (int r = 0; r < ROWS; r++) occ = occ | m_alive[r];
    lo = -1;
    hi = -1;
    for (int c = 0; c < COLS; c++) begin
      if (occ[c]) begin
        if (lo < 0) lo = c;
        hi = c;
      end
    end
    if (m_dir) begin
      if (m_x + hi * 32 + 32 + 2 > 632) begin
        m_y += 8;
        m_dir = 1'b0;
      end else m_x += 2;
    end else begin
      if (m_x + lo * 32 < 10) begin
        m_y += 8;
        m_dir = 1'b1;
      end else m_x -= 2;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      cyc();
    end
    frame_tick = 1'b0;
  endtask

  task automatic step_once();
    ticks(16);
    repeat (COLS + 1) cyc();
  endtask

  task automatic line(input int py, input int exp_r);
    pixel_y = 10'(py);
    line_tick = 1'b1;
    if (exp_r >= 0) exp_q.push_back(row_ev_t'{sel: 3'(exp_r), mask: m_alive[exp_r]});
    cyc();
    line_tick = 1'b0;
    check("row_start_latency", int'(row_start), (exp_r >= 0) ? 1 : 0);
    cyc();
    check("row_start_pulse", int'(row_start), 0);
  endtask

  task automatic kill(input int r, input int c, input bit exp_ack);
    kill_valid = 1'b1;
    kill_row = 3'(r);
    kill_col = 4'(c);
    cyc();
    kill_valid = 1'b0;
    check("kill_ack", int'(kill_ack), int'(exp_ack));
    if (exp_ack) m_alive[r][c] = 1'b0;
    cyc();
    check("kill_ack_pulse", int'(kill_ack), 0);
  endtask

  initial begin
    int drop_at;
    int remaining;

    tbl[0] = '{64, 0};
    tbl[1] = '{96, 1};
    tbl[2] = '{128, 2};
    tbl[3] = '{160, 3};
    tbl[4] = '{192, 4};
    tbl[5] = '{224, -1};
    tbl[6] = '{63, -1};
    tbl[7] = '{97, -1};
    tbl[8] = '{0, -1};

    #1;
    do_reset();

    // First step lands INVADERS_H+1 cycles after the 16th tick.
    ticks(16);
    repeat (COLS) cyc();
    check("step_early_x", int'(spr_x), 26);
    cyc();
    check("step_x", int'(spr_x), 28);
    check("step_y", int'(form_y), 64);
    model_step();

    for (int i = 0; i < 9; i++) line(tbl[i].py, tbl[i].r);

    kill(2, 5, 1'b1);
    kill(2, 5, 1'b0);
    check("alive_count", int'(dut.count_q), 54);
    kill(7, 0, 1'b0);
    kill(0, 11, 1'b0);
    kill(0, 15, 1'b0);
    line(128, 2);
    check("row2_mask", int'(row_mask), 'h7DF);

    // Kill and row capture of the same row in one cycle: mask is pre-kill.
    kill_valid = 1'b1;
    kill_row = 3'd3;
    kill_col = 4'd0;
    pixel_y = 10'd160;
    line_tick = 1'b1;
    exp_q.push_back(row_ev_t'{sel: 3'd3, mask: m_alive[3]});
    cyc();
    kill_valid = 1'b0;
    line_tick = 1'b0;
    check("coincide_ack", int'(kill_ack), 1);
    check("coincide_mask", int'(row_mask), 'h7FF);
    m_alive[3][0] = 1'b0;
    cyc();
    line(160, 3);
    check("row3_after_kill", int'(row_mask), 'h7FE);

    // Column 10 gone: right edge is taken from column 9.
    do_reset();
    for (int r = 0; r < ROWS; r++) kill(r, 10, 1'b1);
    kill(0, 10, 1'b0);
    drop_at = -1;
    for (int s = 0; s < 200; s++) begin
      step_once();
      model_step();
      check("march_x", int'(spr_x), m_x);
      check("march_y", int'(form_y), m_y);
      if (form_y != 10'd64) begin
        drop_at = s;
        break;
      end
    end
    check("drop_step", drop_at, 143);
    check("drop_x", int'(spr_x), 312);
    check("drop_y", int'(form_y), 72);
    step_once();
    model_step();
    check("after_drop_x", int'(spr_x), 310);
    check("after_drop_y", int'(form_y), 72);

    remaining = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) remaining += int'(m_alive[r][c]);
    check("remaining_model", remaining, 50);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (m_alive[r][c]) begin
          if (remaining == 1) begin
            kill_valid = 1'b1;
            kill_row = 3'(r);
            kill_col = 4'(c);
            cyc();
            kill_valid = 1'b0;
            check("last_kill_ack", int'(kill_ack), 1);
            check("all_dead_same_cycle", int'(all_dead), 0);
            m_alive[r][c] = 1'b0;
            cyc();
            check("all_dead", int'(all_dead), 1);
          end else begin
            kill(r, c, 1'b1);
          end
          remaining--;
        end
      end
    end
    cyc();
    check("halt_state", int'(dut.state_q), int'(StHalt));
    step_once();
    step_once();
    check("halt_x", int'(spr_x), m_x);
    check("halt_y", int'(form_y), m_y);
    line(m_y + 64, 2);
    check("empty_row_mask", int'(row_mask), 0);
    kill(1, 1, 1'b0);

    // Reset in the middle of SCAN abandons the step.
    do_reset();
    ticks(16);
    repeat (5) cyc();
    do_reset();
    check("rst_state", int'(dut.state_q), int'(StRun));
    step_once();
    check("post_rst_x", int'(spr_x), 28);
    check("post_rst_y", int'(form_y), 64);

    cyc();
    check("scoreboard_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
